// File: rtl/tristate_bus_pkg.sv
// Shared types and helpers for the tristate bus arbiter family.
// State encoding, default sizing and a one-hot decode helper.
package tristate_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } state_t;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_MAX_HOLD   = 8;
  localparam int DEF_TURNAROUND = 1;

  function automatic int onehot_to_bin(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++)
      if (v[i]) r = i;
    return r;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping past the top index.
module rr_pick
  import tristate_bus_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  winner
);

  logic            found;
  logic [ID_W-1:0] idx;
  int              j;

  always_comb begin
    valid  = |req;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    j      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      idx = ID_W'(j);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate bus with bounded tenure
// and an all-Z turnaround gap between owners.
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int MAX_HOLD   = DEF_MAX_HOLD,
  parameter int TURNAROUND = DEF_TURNAROUND,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] drv_en,
  output logic [ID_W-1:0]  owner_id,
  output logic             bus_busy,
  output logic             turn
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURNAROUND + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [HW-1:0]   hold_cnt;
  logic [TW-1:0]   turn_cnt;

  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic            own_req;
  logic            others;
  logic            hold_top;
  logic [ID_W-1:0] owner_idx;
  logic [ID_W-1:0] next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  assign own_req   = |(req & grant);
  assign others    = |(req & ~grant);
  assign hold_top  = (hold_cnt == HW'(MAX_HOLD - 1));
  assign owner_idx = ID_W'(onehot_to_bin(16'(grant)));
  assign next_ptr  = (owner_idx == ID_W'(N_REQ - 1)) ?
                     '0 : owner_idx + ID_W'(1);
  assign drv_en    = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      owner_id <= '0;
      bus_busy <= 1'b0;
      turn     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            grant    <= ONE << pick_id;
            owner_id <= pick_id;
            bus_busy <= 1'b1;
            hold_cnt <= '0;
            state    <= OWN;
          end
        end
        OWN: begin
          if (!own_req || (hold_top && others)) begin
            grant    <= '0;
            owner_id <= '0;
            bus_busy <= 1'b0;
            turn     <= 1'b1;
            ptr      <= next_ptr;
            turn_cnt <= TW'(TURNAROUND - 1);
            state    <= TURN;
          end else if (!hold_top) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        TURN: begin
          if (turn_cnt != '0) begin
            turn_cnt <= turn_cnt - TW'(1);
          end else begin
            // only req seen on the final gap cycle competes
            turn <= 1'b0;
            if (pick_valid) begin
              grant    <= ONE << pick_id;
              owner_id <= pick_id;
              bus_busy <= 1'b1;
              hold_cnt <= '0;
              state    <= OWN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter (N_REQ=4, MAX_HOLD=8, TURNAROUND=1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tristate_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] drv_en;
  logic [1:0] owner_id;
  logic       bus_busy;
  logic       turn;

  int total;
  int bad;
  bit mon_en;

  tristate_bus_arbiter #(
    .N_REQ      (4),
    .MAX_HOLD   (8),
    .TURNAROUND (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .drv_en   (drv_en),
    .owner_id (owner_id),
    .bus_busy (bus_busy),
    .turn     (turn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if ($countones(drv_en) > 1 || drv_en !== grant ||
          bus_busy !== (|grant) || (turn && bus_busy)) begin
        bad++;
        $display("FAIL invariant: drv_en=%b grant=%b busy=%b turn=%b",
                 drv_en, grant, bus_busy, turn);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    total++;
    if (grant !== 4'b0 || drv_en !== 4'b0 || owner_id !== 2'd0 ||
        bus_busy !== 1'b0 || turn !== 1'b0) begin
      bad++;
      $display("FAIL reset: got g=%b d=%b id=%0d b=%b t=%b want all 0",
               grant, drv_en, owner_id, bus_busy, turn);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    total++;
    if (grant !== 4'b0010 || owner_id !== 2'd1 || bus_busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: got g=%b id=%0d b=%b want 0010 1 1",
               grant, owner_id, bus_busy);
    end
    req = 4'b0000;
    @(negedge clk);
    total++;
    if (grant !== 4'b0 || turn !== 1'b1) begin
      bad++;
      $display("FAIL single_turn: got g=%b t=%b want 0000 1", grant, turn);
    end
    @(negedge clk);
    total++;
    if (grant !== 4'b0 || turn !== 1'b0 || bus_busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: got g=%b t=%b b=%b want 0000 0 0",
               grant, turn, bus_busy);
    end
  endtask

  task automatic test_all_four();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp_g = 4'b0001 << k;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        total++;
        if (grant !== exp_g || owner_id !== 2'(k)) begin
          bad++;
          $display("FAIL rr_tenure k=%0d c=%0d: got g=%b id=%0d want %b %0d",
                   k, c, grant, owner_id, exp_g, k);
        end
      end
      @(negedge clk);
      total++;
      if (drv_en !== 4'b0 || turn !== 1'b1) begin
        bad++;
        $display("FAIL rr_gap k=%0d: got d=%b t=%b want 0000 1",
                 k, drv_en, turn);
      end
    end
    req = 4'b0000;
    @(negedge clk);
    total++;
    if (grant !== 4'b0 || turn !== 1'b0) begin
      bad++;
      $display("FAIL rr_idle: got g=%b t=%b want 0000 0", grant, turn);
    end
  endtask

  task automatic test_lone();
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      total++;
      if (grant !== 4'b0100 || owner_id !== 2'd2) begin
        bad++;
        $display("FAIL lone c=%0d: got g=%b id=%0d want 0100 2",
                 c, grant, owner_id);
      end
    end
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_preempt();
    do_reset();
    req = 4'b1000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (grant !== 4'b1000 || owner_id !== 2'd3) begin
        bad++;
        $display("FAIL preempt_hold c=%0d: got g=%b id=%0d want 1000 3",
                 c, grant, owner_id);
      end
      if (c == 2) req = 4'b1001;
    end
    @(negedge clk);
    total++;
    if (grant !== 4'b0 || turn !== 1'b1) begin
      bad++;
      $display("FAIL preempt_turn: got g=%b t=%b want 0000 1", grant, turn);
    end
    @(negedge clk);
    total++;
    if (grant !== 4'b0001 || owner_id !== 2'd0) begin
      bad++;
      $display("FAIL preempt_wrap: got g=%b id=%0d want 0001 0",
               grant, owner_id);
    end
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_turn_pulse();
    do_reset();
    req = 4'b0001;
    @(negedge clk);
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL pulse_own: got g=%b want 0001", grant);
    end
    req = 4'b0000;
    @(posedge clk);
    #1 req = 4'b0100;
    #2 req = 4'b0000;
    @(negedge clk);
    total++;
    if (grant !== 4'b0 || turn !== 1'b1) begin
      bad++;
      $display("FAIL pulse_turn: got g=%b t=%b want 0000 1", grant, turn);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (grant !== 4'b0 || turn !== 1'b0 || bus_busy !== 1'b0) begin
        bad++;
        $display("FAIL pulse_idle c=%0d: got g=%b t=%b b=%b want 0000 0 0",
                 c, grant, turn, bus_busy);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (grant !== 4'b1000) begin
      bad++;
      $display("FAIL midrst_own: got g=%b want 1000", grant);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (grant !== 4'b0 || drv_en !== 4'b0 || owner_id !== 2'd0 ||
        bus_busy !== 1'b0 || turn !== 1'b0) begin
      bad++;
      $display("FAIL midrst_clear: got g=%b d=%b id=%0d b=%b t=%b want 0",
               grant, drv_en, owner_id, bus_busy, turn);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (grant !== 4'b1000 || owner_id !== 2'd3 || bus_busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_regrant: got g=%b id=%0d b=%b want 1000 3 1",
               grant, owner_id, bus_busy);
    end
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    mon_en = 1'b0;
    rst    = 1'b1;
    req    = 4'b0000;
    test_reset();
    test_single();
    test_all_four();
    test_lone();
    test_preempt();
    test_turn_pulse();
    test_mid_reset();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Round-robin arbiter that shares one tristate bus among N_REQ requesters.
- Each requester drives the bus through a bufif1 whose control pin is one bit of drv_en.
- Guarantees at most one driver enabled at any time, inserts a turnaround gap with all drivers in Z between owners, and bounds bus tenure under contention.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MAX_HOLD, 8, max consecutive owner cycles while another requester waits (>=1).
- TURNAROUND, 1, all-Z cycles between owners (>=1).
- ID_W, $clog2(N_REQ), width of owner_id.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester bus request, level, held while bus wanted.
- grant  output  N_REQ  one-hot (or zero) ownership indication, registered.
- drv_en  output  N_REQ  bufif1 control pins; identical to grant, registered.
- owner_id  output  ID_W  binary index of current owner; 0 when no owner.
- bus_busy  output  1  1 when any grant bit is set.
- turn  output  1  1 during turnaround cycles (all drv_en=0).

Behaviour:
- Reset (rst=1 at clk edge):
  - grant, drv_en, owner_id, bus_busy, turn = 0.
  - state=IDLE; rr pointer=0 (requester 0 has highest priority); hold_cnt=0.
  - Reset mid-tenure drops drv_en on the same edge; no turnaround is inserted.
- States: IDLE, OWN, TURN.
- IDLE:
  - If any req, pick the winner by round-robin starting at rr pointer, scanning upward with wrap.
  - Next edge: grant/drv_en = onehot(winner), owner_id = winner, state=OWN, hold_cnt=0.
  - Request-to-grant latency is 1 cycle from an idle bus.
- OWN:
  - hold_cnt increments each cycle and saturates at MAX_HOLD-1.
  - Release when req[owner]=0, or when hold_cnt==MAX_HOLD-1 and any other req bit is set.
  - Release edge: grant/drv_en=0, rr pointer = owner+1 (mod N_REQ), state=TURN, turn=1, TURNAROUND counter loaded.
  - If the owner keeps req and no other requester is pending, tenure is unlimited and hold_cnt stays saturated.
- TURN:
  - All drv_en=0 for exactly TURNAROUND cycles.
  - On the last TURN cycle, arbitrate with the updated rr pointer.
  - If any req: next edge goes directly to OWN with the new winner.
  - Otherwise: IDLE.
  - Minimum gap between two owners' drv_en is exactly TURNAROUND cycles.
- Requests sampled during TURN are not latched; only req on the last TURN cycle counts.
- A requester dropping req during TURN is not granted.
- The previous owner may win again after TURN only if no other requester is pending (round-robin fairness).
- Invariant: popcount(drv_en) <= 1 every cycle; drv_en==grant; bus_busy == |grant; turn and bus_busy never both 1.
- Arbitration is combinational from req and rr pointer. All outputs are flops, with no combinational req-to-output path.

Decomposition:
- Shared package tristate_bus_pkg: state enum (IDLE/OWN/TURN), default parameter constants, function onehot_to_bin.
- One natural sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req, rr pointer.
  - Outputs: valid, winner index.
  - Reusable by other arbiters in the codebase.

Test Plan:
- Reset then single request: req=0010 -> one cycle later grant=drv_en=0010, owner_id=1, bus_busy=1. req drops -> grant=0, turn=1 for 1 cycle, then IDLE.
- Simultaneous req=1111 after reset -> grant order 0,1,2,3 (pointer wraps). Each tenure is 8 cycles (MAX_HOLD), separated by exactly 1 turn cycle with drv_en=0000.
- Lone continuous requester req=0100 for 30 cycles -> grant stays 0100 for all 30 cycles with no preemption.
- Owner 3 holds; req[0] asserts at hold_cnt=2 -> owner 3 released after hold_cnt reaches 7, turn cycle follows, then grant=0001 (wrap from 3 to 0).
- Requester 2 pulses req only during TURN and drops before the last TURN cycle -> not granted; bus goes IDLE.
- Reset asserted mid-tenure (grant=1000) -> next edge all outputs 0, state IDLE. With req=1000 still held, grant returns one cycle after rst deasserts. popcount(drv_en)<=1 asserted every cycle throughout.
